// File: rtl/tlv_host_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tlv_host_pkg
// Brief   : Type codes, status codes and FSM encoding for tlv_host_loader.
// Revision: 1.0 - initial release
// ============================================================================
package tlv_host_pkg;

    localparam logic [7:0] c_type_clear = 8'h7D;
    localparam logic [7:0] c_type_dump  = 8'h7E;
    localparam logic [7:0] c_type_start = 8'h7F;

    localparam logic [7:0] c_st_ok       = 8'h00;
    localparam logic [7:0] c_st_bad_type = 8'hE1;
    localparam logic [7:0] c_st_overflow = 8'hE2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN0    = 3'd1,
        S_LEN1    = 3'd2,
        S_VALUE   = 3'd3,
        S_DISCARD = 3'd4,
        S_RESP    = 3'd5,
        S_DUMP    = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tlv_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module  : tlv_cycle_counter
// Brief   : Saturating interval counter opened by evt_start, closed by evt_stop.
// Revision: 1.0 - initial release
// ============================================================================
module tlv_cycle_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             evt_start,
    input  logic             evt_stop,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] value_q, value_d;
    logic             running_q, running_d;

    always_comb begin
        value_d   = value_q;
        running_d = running_q;
        if (evt_start) begin
            value_d   = '0;
            running_d = 1'b1;
        end else if (running_q) begin
            // The closing cycle itself is counted, so start..stop N cycles apart reads N.
            if (value_q != {CNT_W{1'b1}}) begin
                value_d = value_q + CNT_W'(1);
            end
            if (evt_stop) begin
                running_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q   <= '0;
            running_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            running_q <= running_d;
        end
    end

    assign value = value_q;

endmodule
`default_nettype wire

// File: rtl/tlv_host_loader.sv
`default_nettype none
// ============================================================================
// Module  : tlv_host_loader
// Brief   : TLV byte-stream decoder packing payloads into per-channel memories,
//           with core start, profile counters and UART status/dump replies.
// Revision: 1.0 - initial release
// ============================================================================
module tlv_host_loader #(
    parameter int NUM_CH  = 2,
    parameter int WORD_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int LEN_W   = 16,
    parameter int NUM_CNT = 3,
    parameter int CNT_W   = 64
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     rx_valid,
    input  logic [7:0]                               rx_data,
    output logic                                     tx_valid,
    output logic [7:0]                               tx_data,
    input  logic                                     tx_done,
    output logic                                     wr_en,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
    output logic [ADDR_W-1:0]                        wr_addr,
    output logic [WORD_W-1:0]                        wr_data,
    output logic                                     start,
    input  logic [NUM_CNT-1:0]                       evt_start,
    input  logic [NUM_CNT-1:0]                       evt_stop,
    output logic                                     busy,
    output logic                                     rx_drop
);
    import tlv_host_pkg::*;

    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LANES      = WORD_W / 8;
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int DUMP_BYTES = NUM_CNT * CNT_W / 8;
    localparam int DIDX_W     = (DUMP_BYTES > 1) ? $clog2(DUMP_BYTES) : 1;

    state_t                         state_q, state_d;
    logic [7:0]                     type_q, type_d;
    logic [7:0]                     len_lo_q, len_lo_d;
    logic [LEN_W-1:0]               rem_q, rem_d;
    logic [LANE_W-1:0]              lane_q, lane_d;
    logic [WORD_W-1:0]              buf_q, buf_d;
    logic [7:0]                     status_q, status_d;
    logic [CH_W-1:0]                ch_q, ch_d;
    logic [NUM_CH-1:0][ADDR_W-1:0]  ptr_q, ptr_d;
    logic [NUM_CH-1:0]              sat_q, sat_d;
    logic [DIDX_W-1:0]              dump_idx_q, dump_idx_d;
    logic                           tx_valid_q, tx_valid_d;
    logic [7:0]                     tx_data_q, tx_data_d;
    logic                           wr_en_q, wr_en_d;
    logic [CH_W-1:0]                wr_ch_q, wr_ch_d;
    logic [ADDR_W-1:0]              wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]              wr_data_q, wr_data_d;
    logic                           start_q, start_d;
    logic                           rx_drop_q, rx_drop_d;

    logic [NUM_CNT*CNT_W-1:0]       w_cnt_flat;
    logic [LEN_W-1:0]               w_len;
    logic [WORD_W-1:0]              w_word;
    logic                           w_is_write;
    logic                           w_is_ctrl;

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        tlv_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .evt_start (evt_start[i]),
            .evt_stop  (evt_stop[i]),
            .value     (w_cnt_flat[i*CNT_W +: CNT_W])
        );
    end

    always_comb begin
        w_len      = LEN_W'({rx_data, len_lo_q});
        w_is_write = (type_q != 8'h00) && (type_q <= 8'(NUM_CH));
        w_is_ctrl  = (type_q == c_type_clear) || (type_q == c_type_dump) ||
                     (type_q == c_type_start);
        w_word     = buf_q;
        w_word[{lane_q, 3'b000} +: 8] = rx_data;

        state_d    = state_q;
        type_d     = type_q;
        len_lo_d   = len_lo_q;
        rem_d      = rem_q;
        lane_d     = lane_q;
        buf_d      = buf_q;
        status_d   = status_q;
        ch_d       = ch_q;
        ptr_d      = ptr_q;
        sat_d      = sat_q;
        dump_idx_d = dump_idx_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        wr_en_d    = 1'b0;
        wr_ch_d    = wr_ch_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        start_d    = 1'b0;
        rx_drop_d  = rx_drop_q;

        case (state_q)
            S_IDLE: begin
                if (rx_valid && (rx_data != 8'h00)) begin
                    type_d  = rx_data;
                    state_d = S_LEN0;
                end
            end
            S_LEN0: begin
                if (rx_valid) begin
                    len_lo_d = rx_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (rx_valid) begin
                    status_d = c_st_ok;
                    rem_d    = w_len;
                    lane_d   = '0;
                    buf_d    = '0;
                    if (w_is_write) begin
                        ch_d    = CH_W'(type_q - 8'd1);
                        state_d = (w_len == '0) ? S_RESP : S_VALUE;
                    end else if (!w_is_ctrl || (w_len != '0)) begin
                        status_d = c_st_bad_type;
                        state_d  = (w_len == '0) ? S_RESP : S_DISCARD;
                    end else if (type_q == c_type_clear) begin
                        ptr_d   = '0;
                        sat_d   = '0;
                        state_d = S_RESP;
                    end else if (type_q == c_type_start) begin
                        start_d = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        dump_idx_d = '0;
                        state_d    = S_DUMP;
                    end
                end
            end
            S_VALUE: begin
                if (rx_valid) begin
                    rem_d = rem_q - LEN_W'(1);
                    if ((lane_q == LANE_W'(LANES - 1)) || (rem_q == LEN_W'(1))) begin
                        buf_d  = '0;
                        lane_d = '0;
                        // Once the last address has been written the channel is full.
                        if (sat_q[ch_q]) begin
                            status_d = c_st_overflow;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_ch_d   = ch_q;
                            wr_addr_d = ptr_q[ch_q];
                            wr_data_d = w_word;
                            if (ptr_q[ch_q] == {ADDR_W{1'b1}}) begin
                                sat_d[ch_q] = 1'b1;
                            end else begin
                                ptr_d[ch_q] = ptr_q[ch_q] + ADDR_W'(1);
                            end
                        end
                    end else begin
                        buf_d  = w_word;
                        lane_d = lane_q + LANE_W'(1);
                    end
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_DISCARD: begin
                if (rx_valid) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rx_valid) begin
                    rx_drop_d = 1'b1;
                end
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = status_q;
                end else if (tx_done) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_DUMP: begin
                if (rx_valid) begin
                    rx_drop_d = 1'b1;
                end
                // tx_valid drops for a cycle between bytes so each request is a fresh edge.
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = w_cnt_flat[{dump_idx_q, 3'b000} +: 8];
                end else if (tx_done) begin
                    tx_valid_d = 1'b0;
                    if (dump_idx_q == DIDX_W'(DUMP_BYTES - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        dump_idx_d = dump_idx_q + DIDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            type_q     <= '0;
            len_lo_q   <= '0;
            rem_q      <= '0;
            lane_q     <= '0;
            buf_q      <= '0;
            status_q   <= '0;
            ch_q       <= '0;
            ptr_q      <= '0;
            sat_q      <= '0;
            dump_idx_q <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_ch_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            start_q    <= 1'b0;
            rx_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            len_lo_q   <= len_lo_d;
            rem_q      <= rem_d;
            lane_q     <= lane_d;
            buf_q      <= buf_d;
            status_q   <= status_d;
            ch_q       <= ch_d;
            ptr_q      <= ptr_d;
            sat_q      <= sat_d;
            dump_idx_q <= dump_idx_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            wr_en_q    <= wr_en_d;
            wr_ch_q    <= wr_ch_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            start_q    <= start_d;
            rx_drop_q  <= rx_drop_d;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign wr_en    = wr_en_q;
    assign wr_ch    = wr_ch_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign start    = start_q;
    assign busy     = (state_q != S_IDLE);
    assign rx_drop  = rx_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_tlv_host_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_tlv_host_loader
// Brief   : Scoreboard bench for tlv_host_loader (default and ADDR_W=2 builds).
// Revision: 1.0 - initial release
// ============================================================================
module tb_tlv_host_loader;

    typedef struct {
        logic [0:0]  ch;
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid_a = 1'b0;
    logic        rx_valid_b = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_done = 1'b0;
    logic [2:0]  evt_start = 3'b000;
    logic [2:0]  evt_stop = 3'b000;

    logic        a_tx_valid, a_wr_en, a_start, a_busy, a_rx_drop;
    logic [7:0]  a_tx_data;
    logic [0:0]  a_wr_ch;
    logic [3:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic        b_tx_valid, b_wr_en, b_start, b_busy, b_rx_drop;
    logic [7:0]  b_tx_data;
    logic [0:0]  b_wr_ch;
    logic [1:0]  b_wr_addr;
    logic [31:0] b_wr_data;

    wr_t         wq[$];
    logic [7:0]  tq[$];
    int          vec = 0;
    int          miss = 0;
    int          start_cnt = 0;

    always #5 clk = ~clk;

    tlv_host_loader u_dut_a (
        .clk(clk), .rst(rst), .rx_valid(rx_valid_a), .rx_data(rx_data),
        .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_done(tx_done),
        .wr_en(a_wr_en), .wr_ch(a_wr_ch), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .start(a_start), .evt_start(evt_start), .evt_stop(evt_stop),
        .busy(a_busy), .rx_drop(a_rx_drop)
    );

    tlv_host_loader #(.ADDR_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .rx_valid(rx_valid_b), .rx_data(rx_data),
        .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_done(tx_done),
        .wr_en(b_wr_en), .wr_ch(b_wr_ch), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .start(b_start), .evt_start(evt_start), .evt_stop(evt_stop),
        .busy(b_busy), .rx_drop(b_rx_drop)
    );

    // Write-port scoreboard: both DUTs share one expectation queue.
    always @(negedge clk) begin
        if (a_start === 1'b1) start_cnt++;
        if (a_wr_en === 1'b1 || b_wr_en === 1'b1) begin
            logic [0:0]  m_ch;
            logic [3:0]  m_addr;
            logic [31:0] m_data;
            m_ch   = (a_wr_en === 1'b1) ? a_wr_ch : b_wr_ch;
            m_addr = (a_wr_en === 1'b1) ? a_wr_addr : {2'b00, b_wr_addr};
            m_data = (a_wr_en === 1'b1) ? a_wr_data : b_wr_data;
            vec++;
            if (wq.size() == 0) begin
                miss++;
                $display("FAIL wr_unexpected: got ch=%0d addr=%0d data=%h, required no write",
                         m_ch, m_addr, m_data);
            end else begin
                wr_t e;
                e = wq.pop_front();
                if (m_ch !== e.ch || m_addr !== e.addr || m_data !== e.data) begin
                    miss++;
                    $display("FAIL wr_word: got ch=%0d addr=%0d data=%h, required ch=%0d addr=%0d data=%h",
                             m_ch, m_addr, m_data, e.ch, e.addr, e.data);
                end
            end
        end
    end

    // Transmitter model: compare each requested byte, then acknowledge after a delay.
    initial begin
        forever begin
            @(negedge clk);
            if (a_tx_valid === 1'b1 || b_tx_valid === 1'b1) begin
                logic [7:0] got;
                got = (a_tx_valid === 1'b1) ? a_tx_data : b_tx_data;
                vec++;
                if (tq.size() == 0) begin
                    miss++;
                    $display("FAIL tx_unexpected: got %h, required no byte", got);
                end else begin
                    logic [7:0] exp;
                    exp = tq.pop_front();
                    if (got !== exp) begin
                        miss++;
                        $display("FAIL tx_byte: got %h, required %h", got, exp);
                    end
                end
                repeat (2) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit to_b);
        @(negedge clk);
        rx_data = b;
        if (to_b) rx_valid_b = 1'b1;
        else      rx_valid_a = 1'b1;
        @(negedge clk);
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] t, input int len, input logic [7:0] first,
                              input logic [7:0] step, input bit to_b);
        logic [7:0] b;
        send_byte(t, to_b);
        send_byte(len[7:0], to_b);
        send_byte(len[15:8], to_b);
        b = first;
        for (int i = 0; i < len; i++) begin
            send_byte(b, to_b);
            b = b + step;
        end
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        while ((a_busy !== 1'b0 || b_busy !== 1'b0 || tq.size() != 0 || wq.size() != 0)
               && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        vec++;
        if (cyc >= 3000) begin
            miss++;
            $display("FAIL %s_timeout: got busy=%b/%b tq=%0d wq=%0d, required idle 0/0",
                     name, a_busy, b_busy, tq.size(), wq.size());
            tq.delete();
            wq.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vec++;
        if ({a_tx_valid, a_wr_en, a_start, a_busy, a_rx_drop} !== 5'b0) begin
            miss++;
            $display("FAIL reset_ctrl: got %b, required 00000",
                     {a_tx_valid, a_wr_en, a_start, a_busy, a_rx_drop});
        end
        vec++;
        if ({a_tx_data, a_wr_ch, a_wr_addr, a_wr_data} !== 45'b0) begin
            miss++;
            $display("FAIL reset_data: got %h, required 0",
                     {a_tx_data, a_wr_ch, a_wr_addr, a_wr_data});
        end
    endtask

    task automatic test_write();
        wq.push_back('{1'b0, 4'd0, 32'h04030201});
        wq.push_back('{1'b0, 4'd1, 32'h08070605});
        tq.push_back(8'h00);
        send_frame(8'h01, 8, 8'h01, 8'h01, 1'b0);
        wait_done("write8");
        wq.push_back('{1'b0, 4'd2, 32'hDDCCBBAA});
        wq.push_back('{1'b0, 4'd3, 32'h000000EE});
        tq.push_back(8'h00);
        send_frame(8'h01, 5, 8'hAA, 8'h11, 1'b0);
        wait_done("write5");
    endtask

    task automatic test_clear();
        tq.push_back(8'h00);
        send_frame(8'h7D, 0, 8'h00, 8'h00, 1'b0);
        wait_done("clear");
        wq.push_back('{1'b1, 4'd0, 32'h44332211});
        tq.push_back(8'h00);
        send_frame(8'h02, 4, 8'h11, 8'h11, 1'b0);
        wait_done("ch1");
        wq.push_back('{1'b0, 4'd0, 32'h24232221});
        tq.push_back(8'h00);
        send_frame(8'h01, 4, 8'h21, 8'h01, 1'b0);
        wait_done("ch0_after_clear");
    endtask

    task automatic test_unknown();
        int sc;
        send_byte(8'h00, 1'b0);
        vec++;
        if (a_busy !== 1'b0) begin
            miss++;
            $display("FAIL type0_ignored: got busy=%b, required 0", a_busy);
        end
        tq.push_back(8'hE1);
        send_frame(8'h55, 3, 8'h10, 8'h01, 1'b0);
        wait_done("unknown");
        sc = start_cnt;
        tq.push_back(8'hE1);
        send_frame(8'h7F, 1, 8'h00, 8'h00, 1'b0);
        wait_done("start_nonzero_len");
        vec++;
        if (start_cnt !== sc) begin
            miss++;
            $display("FAIL start_len1: got %0d pulses, required 0", start_cnt - sc);
        end
        wq.push_back('{1'b0, 4'd1, 32'h00005B5A});
        tq.push_back(8'h00);
        send_frame(8'h01, 2, 8'h5A, 8'h01, 1'b0);
        wait_done("after_unknown");
    endtask

    task automatic test_overflow();
        wq.push_back('{1'b0, 4'd0, 32'h04030201});
        wq.push_back('{1'b0, 4'd1, 32'h08070605});
        wq.push_back('{1'b0, 4'd2, 32'h0C0B0A09});
        wq.push_back('{1'b0, 4'd3, 32'h100F0E0D});
        tq.push_back(8'hE2);
        send_frame(8'h01, 24, 8'h01, 8'h01, 1'b1);
        wait_done("overflow");
    endtask

    task automatic test_start_dump();
        int sc;
        sc = start_cnt;
        tq.push_back(8'h00);
        send_byte(8'h7F, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        vec++;
        if (a_start !== 1'b1) begin
            miss++;
            $display("FAIL start_timing: got %b, required 1", a_start);
        end
        wait_done("start");
        vec++;
        if (start_cnt - sc !== 1) begin
            miss++;
            $display("FAIL start_count: got %0d, required 1", start_cnt - sc);
        end
        @(negedge clk);
        evt_start = 3'b010;
        @(negedge clk);
        evt_start = 3'b000;
        repeat (99) @(negedge clk);
        evt_stop = 3'b010;
        @(negedge clk);
        evt_stop = 3'b000;
        repeat (20) @(negedge clk);
        vec++;
        if (a_rx_drop !== 1'b0) begin
            miss++;
            $display("FAIL rx_drop_pre: got %b, required 0", a_rx_drop);
        end
        for (int i = 0; i < 24; i++) tq.push_back((i == 8) ? 8'h64 : 8'h00);
        send_frame(8'h7E, 0, 8'h00, 8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        wait_done("dump");
        vec++;
        if (a_rx_drop !== 1'b1) begin
            miss++;
            $display("FAIL rx_drop_dump: got %b, required 1", a_rx_drop);
        end
    endtask

    task automatic test_rst_mid();
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vec++;
        if ({a_busy, a_rx_drop, a_wr_en} !== 3'b000) begin
            miss++;
            $display("FAIL rst_mid: got busy/drop/wr=%b, required 000",
                     {a_busy, a_rx_drop, a_wr_en});
        end
        wq.push_back('{1'b0, 4'd0, 32'h44332211});
        tq.push_back(8'h00);
        send_frame(8'h01, 4, 8'h11, 8'h11, 1'b0);
        wait_done("after_rst");
    endtask

    initial begin
        test_reset();
        test_write();
        test_clear();
        test_unknown();
        test_overflow();
        test_start_dump();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/tlv_host_loader.md
# tlv_host_loader

Parametrised UART-side host loader for the Classic McEliece cores. It decodes a TLV byte stream from the UART receiver and packs payloads into words for up to NUM_CH destination memories (seed, public key, ...) using persistent per-channel append pointers. It issues a one-cycle core start, measures NUM_CNT cycle intervals, and streams a status byte or the profile counters back through the UART transmitter. It sits between the `Receiver`/`Transmitter` pair and the encap/decap top level.

## Interface
- NUM_CH, 2 — number of destination memories; channel c is TLV type c+1.
- WORD_W, 32 — memory word width; multiple of 8, ≥ 8.
- ADDR_W, 4 — per-channel word address width; capacity 2^ADDR_W words.
- LEN_W, 16 — TLV length field width; fixed at 16, two bytes little-endian.
- NUM_CNT, 3 — number of profile interval counters.
- CNT_W, 64 — counter width; multiple of 8.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- rx_valid  in  1  one-cycle pulse, rx_data is valid.
- rx_data  in  8  received byte.
- tx_valid  out  1  byte request to the transmitter; held until tx_done.
- tx_data  out  8  byte to send; stable while tx_valid is high.
- tx_done  in  1  one-cycle pulse, current byte has been sent.
- wr_en  out  1  one-cycle memory write strobe.
- wr_ch  out  max(1,ceil(log2 NUM_CH))  destination channel.
- wr_addr  out  ADDR_W  word address.
- wr_data  out  WORD_W  packed word; first byte in bits [7:0].
- start  out  1  one-cycle core start pulse.
- evt_start  in  NUM_CNT  per-counter interval-open pulse.
- evt_stop  in  NUM_CNT  per-counter interval-close pulse.
- busy  out  1  high whenever the FSM is not in IDLE.
- rx_drop  out  1  sticky; a byte arrived in RESP or DUMP. Cleared only by rst.

## Operation
- Type codes: 0x01..NUM_CH = write to channel (type−1); 0x7D = clear all append pointers; 0x7E = dump counters; 0x7F = start. Type 0x00 in IDLE is ignored.
- FSM states: IDLE → LEN0 → LEN1 → {VALUE | DISCARD | RESP | DUMP}.
  - A byte in IDLE latches the type.
  - LEN0 captures the length low byte; LEN1 captures the high byte.
- Write frame:
  - len = 0 → RESP with status 0x00.
  - Otherwise VALUE. Each byte fills lane byte_idx of the word buffer.
  - When the lane index reaches WORD_W/8−1, or on the frame's last byte, emit wr_en with wr_addr = ptr[ch], then increment ptr[ch].
  - A partial last word is zero-padded in its upper lanes.
- Overflow: a word is due while ptr[ch] = 2^ADDR_W−1 has already been written (saturated flag set).
  - The word is dropped and status becomes 0xE2.
  - Remaining bytes are consumed without writes.
- Unknown type, or a nonzero length on 0x7D/0x7E/0x7F: consume len bytes in DISCARD, then RESP with 0xE1.
- 0x7D: clear all ptr and saturated flags; RESP 0x00.
- 0x7F: pulse start; RESP 0x00.
- 0x7E: enter DUMP. Send NUM_CNT·CNT_W/8 bytes: counter 0 first, LSB first. No status byte follows. Return to IDLE.
- Counter i:
  - evt_start[i] clears it to 0 and sets running.
  - Increments by 1 each cycle while running.
  - evt_stop[i] clears running; the value holds.
  - evt_start and evt_stop in the same cycle count as a restart.
  - Saturates at all-ones.
- RESP: send one status byte, then return to IDLE.

## Timing
- Reset values: tx_valid, wr_en, start, busy, rx_drop = 0; tx_data, wr_ch, wr_addr, wr_data = 0; all pointers, counters and flags = 0; FSM in IDLE.
- wr_en asserts in the cycle after the rx_valid that completes the word.
- start pulses in the cycle after the LEN1 byte. The start pulse does not itself open any counter; only evt_start does.
- tx_valid rises in the cycle after entering RESP, or after each tx_done in DUMP. Exactly one byte is in flight at a time.
- No back-pressure on rx: one byte is accepted per rx_valid pulse. Bytes arriving in RESP or DUMP are discarded and set rx_drop.
- rst mid-frame, mid-send or mid-dump returns everything to reset values next cycle. No partial word is written.

## Structure
- Package `tlv_host_pkg`:
  - type codes 0x7D/0x7E/0x7F;
  - status codes 0x00/0xE1/0xE2;
  - FSM state encoding.
- Sub-module `tlv_cycle_counter`: one instance per counter, parameter CNT_W. Inputs clk, rst, evt_start, evt_stop; output value.

## Test plan
- Type 0x01, len 0x0008, bytes 01..08 → writes ch0 addr0 = 0x04030201 and addr1 = 0x08070605; tx byte 0x00.
- Second 0x01 frame, len 0x0005, bytes AA..EE → addr2 = 0xDDCCBBAA and addr3 = 0x000000EE. Then a 0x7D frame, then a 0x02 frame → writes ch1 addr0.
- Type 0x55, len 0x0003, 3 bytes → no wr_en; tx byte 0xE1; a following valid frame decodes normally.
- ADDR_W = 2, 0x01 frame with 24 bytes → 4 writes (addr0..3); tx byte 0xE2.
- 0x7F len 0 → one start pulse; evt_start[1] then evt_stop[1] 100 cycles later; 0x7E → 24 bytes with byte 8 = 0x64 and all others 0.
- rst asserted mid-VALUE after 2 bytes → no wr_en, busy = 0; a new frame is accepted from IDLE at addr0.
